imem_loader: RTL and testbench

Boot-time program loader directly upstream of `cpu`. It drives the CPU's instruction-memory external port (`addr_ext`, `wen_ext`, `ren_ext`, `wdata_ext`) from a valid/ready word stream. It then reads the whole image back and checks it with a checksum. It raises `enable` only after a passing check, so the pipeline never fetches from a partially written or corrupt image.

---
 rtl/imem_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader that sits in front of the CPU's instruction-memory
// external port. It works in four steps:
//   1. Accept an image of num_words words from a valid/ready stream and write
//      it into instruction memory.
//   2. Read the whole image back.
//   3. Compare a write-side checksum with a read-side checksum.
//   4. Raise the CPU run enable only if the two checksums match.
// The CPU therefore never fetches from a partially written or corrupt image.
//
// Parameters:
//   DATA_W     word width of the stream and of the memory port
//   DEPTH      maximum image size in words
//   BASE_ADDR  byte address of word 0 (word i sits at BASE_ADDR + 4*i)
//
// Ports:
//   clk        single clock, shared with the CPU
//   arst_n     asynchronous active-low reset
//   start      one-cycle pulse that begins a load (honoured in IDLE/RUN/FAIL)
//   num_words  image length in words, latched on an accepted start
//   s_valid    stream word valid
//   s_data     stream word
//   s_ready    loader accepts s_data this cycle (high throughout LOAD)
//   rdata_ext  readback from instruction memory, valid one cycle after ren_ext
//   addr_ext   byte address to instruction memory
//   wen_ext    write strobe
//   ren_ext    read strobe
//   wdata_ext  write data
//   enable     CPU run enable (RUN only)
//   busy       high in LOAD, VERIFY and CHECK
//   done       high in RUN
//   error      high in FAIL
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_words,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        rdata_ext,
    output logic [31:0]              addr_ext,
    output logic                     wen_ext,
    output logic                     ren_ext,
    output logic [DATA_W-1:0]        wdata_ext,
    output logic                     enable,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    // Counter width. It must hold DEPTH itself, not just DEPTH-1, because
    // num_words == DEPTH is a legal full-size image.
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_CHECK,
        S_RUN,
        S_FAIL
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    num_q,     num_d;      // latched image length
    logic [CNT_W-1:0]    wcnt_q,    wcnt_d;     // words accepted from the stream
    logic [CNT_W-1:0]    rcnt_q,    rcnt_d;     // reads issued
    logic [CNT_W-1:0]    ack_cnt_q, ack_cnt_d;  // readbacks accumulated
    logic [DATA_W-1:0]   sum_wr_q,  sum_wr_d;
    logic [DATA_W-1:0]   sum_rd_q,  sum_rd_d;
    logic                rd_pend_q, rd_pend_d;  // rdata_ext valid this cycle

    // Memory-port outputs are registered so the instruction memory sees
    // clean, glitch-free strobes.
    logic [31:0]         addr_q,    addr_d;
    logic                wen_q,     wen_d;
    logic                ren_q,     ren_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;

    // Byte address of word idx. No wrap: the largest index is DEPTH-1.
    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        return BASE_ADDR + (32'(idx) << 2);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        num_d     = num_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        ack_cnt_d = ack_cnt_q;
        sum_wr_d  = sum_wr_q;
        sum_rd_d  = sum_rd_q;
        // The read issued last cycle returns its data this cycle.
        rd_pend_d = ren_q;
        // Strobes are single-cycle. Address and data are zero whenever no
        // strobe is active.
        addr_d    = '0;
        wen_d     = 1'b0;
        ren_d     = 1'b0;
        wdata_d   = '0;

        unique case (state_q)
            S_IDLE, S_RUN, S_FAIL: begin
                if (start) begin
                    num_d     = num_words;
                    wcnt_d    = '0;
                    rcnt_d    = '0;
                    ack_cnt_d = '0;
                    sum_wr_d  = '0;
                    sum_rd_d  = '0;
                    if (num_words > CNT_W'(DEPTH)) begin
                        state_d = S_FAIL;
                    end else if (num_words == '0) begin
                        // An empty image has two zero checksums, so it
                        // passes straight through CHECK.
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                // s_ready is constant high in LOAD, so a handshake is just
                // s_valid.
                if (s_valid) begin
                    wen_d    = 1'b1;
                    addr_d   = word_addr(wcnt_q);
                    wdata_d  = s_data;
                    wcnt_d   = wcnt_q + CNT_W'(1);
                    sum_wr_d = sum_wr_q + s_data;
                    if (wcnt_q == num_q - CNT_W'(1)) begin
                        state_d = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                // Issue side: one read per cycle until all N are out.
                if (rcnt_q < num_q) begin
                    ren_d  = 1'b1;
                    addr_d = word_addr(rcnt_q);
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
                // Return side: accumulate each readback one cycle behind its
                // read. Leave VERIFY once the Nth word is summed.
                if (rd_pend_q) begin
                    sum_rd_d  = sum_rd_q + rdata_ext;
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                    if (ack_cnt_q == num_q - CNT_W'(1)) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                state_d = (sum_wr_q == sum_rd_q) ? S_RUN : S_FAIL;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ack_cnt_q <= '0;
            sum_wr_q  <= '0;
            sum_rd_q  <= '0;
            rd_pend_q <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples its
            // next value from the same pre-edge snapshot.
            state_q   <= state_d;
            num_q     <= num_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            ack_cnt_q <= ack_cnt_d;
            sum_wr_q  <= sum_wr_d;
            sum_rd_q  <= sum_rd_d;
            rd_pend_q <= rd_pend_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            wdata_q   <= wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Status flags decode directly from the state register, so they are
    // glitch-free and fall to 0 with the asynchronous reset.
    assign s_ready   = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY) ||
                       (state_q == S_CHECK);
    assign done      = (state_q == S_RUN);
    assign enable    = (state_q == S_RUN);
    assign error     = (state_q == S_FAIL);

    assign addr_ext  = addr_q;
    assign wen_ext   = wen_q;
    assign ren_ext   = ren_q;
    assign wdata_ext = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Each test queues the writes and reads it
// expects, with the cycle each should appear in, as it drives the stream. A
// monitor pops and compares those entries whenever the DUT raises a strobe.
// A small memory model echoes writes back on reads. It can be told to
// corrupt the word at byte address 0x4.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 512;
    localparam logic [31:0] BASE   = 32'h0;

    logic                   clk;
    logic                   arst_n;
    logic                   start;
    logic [$clog2(DEPTH):0] num_words;
    logic                   s_valid;
    logic [DATA_W-1:0]      s_data;
    logic                   s_ready;
    logic [DATA_W-1:0]      rdata_ext;
    logic [31:0]            addr_ext;
    logic                   wen_ext;
    logic                   ren_ext;
    logic [DATA_W-1:0]      wdata_ext;
    logic                   enable;
    logic                   busy;
    logic                   done;
    logic                   error;

    imem_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .rdata_ext (rdata_ext),
        .addr_ext  (addr_ext),
        .wen_ext   (wen_ext),
        .ren_ext   (ren_ext),
        .wdata_ext (wdata_ext),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;   // posedges seen so far
    int t0       = 0;   // edge_cnt just after the edge that sampled start

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Cycle number relative to the start pulse (the start cycle is cycle 0).
    function automatic int rel_cyc();
        return edge_cnt - t0 + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } xact_t;

    xact_t wr_q[$];
    xact_t rd_q[$];

    // ---------------------------------------------------------------------
    // Instruction-memory model: synchronous write, one-cycle read latency
    // ---------------------------------------------------------------------
    logic [31:0] mem [0:DEPTH-1];
    bit          corrupt = 1'b0;

    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= (corrupt && addr_ext == 32'h4) ? 32'hDEAD_BEEF
                                                                  : mem[addr_ext[10:2]];
    end

    // ---------------------------------------------------------------------
    // Port monitor and scoreboard (samples on the falling edge)
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        xact_t e;
        if (arst_n) begin
            if (wen_ext) begin
                check("wen_ren_exclusive", 32'(ren_ext), 32'd0);
                if (wr_q.size() == 0) begin
                    check("write_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("write_addr",  addr_ext,        e.addr);
                    check("write_data",  wdata_ext,       e.data);
                    check("write_cycle", 32'(rel_cyc()),  32'(e.cyc));
                end
            end else if (ren_ext) begin
                if (rd_q.size() == 0) begin
                    check("read_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("read_addr",  addr_ext,       e.addr);
                    check("read_cycle", 32'(rel_cyc()), 32'(e.cyc));
                end
            end else begin
                check("port_idle_zero", addr_ext | wdata_ext, 32'd0);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    logic [31:0] img [0:DEPTH-1];

    task automatic pulse_start(input int n);
        num_words = ($clog2(DEPTH)+1)'(n);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        t0        = edge_cnt;
    endtask

    // Load img[0..n-1] and wait for RUN or FAIL.
    //   stall    : s_valid low on even cycles
    //   poke_cyc : cycle in which a stray start (num_words=513) is pulsed
    //   exp_pass : whether the checksum is expected to match
    task automatic run_load(input int n, input bit stall, input int poke_cyc, input bit exp_pass);
        int i;
        int k;
        int last_hs;
        int exp_end;
        int got;
        pulse_start(n);
        i = 0;
        k = 1;
        last_hs = 0;
        while (i < n) begin
            s_valid = stall ? (k % 2 == 1) : 1'b1;
            s_data  = img[i];
            if (k == poke_cyc) begin
                start     = 1'b1;
                num_words = 10'd513;
            end
            @(negedge clk);
            check("s_ready_in_load", 32'(s_ready), 32'd1);
            if (k == 1) begin
                check("busy_cycle1",   32'(busy),   32'd1);
                check("enable_cycle1", 32'(enable), 32'd0);
                check("done_cycle1",   32'(done),   32'd0);
            end
            if (s_valid) begin
                wr_q.push_back('{addr: BASE + 32'(4*i), data: img[i], cyc: k + 1});
                i++;
                last_hs = k;
            end
            @(posedge clk);
            #1;
            start     = 1'b0;
            num_words = ($clog2(DEPTH)+1)'(n);
            k++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        for (int j = 0; j < n; j++)
            rd_q.push_back('{addr: BASE + 32'(4*j), data: 32'd0, cyc: last_hs + 2 + j});
        // Cycle last_hs+1: VERIFY for n>0, or CHECK for n==0.
        @(negedge clk);
        check("s_ready_after_load", 32'(s_ready), 32'd0);
        check("busy_after_load",    32'(busy),    32'd1);
        exp_end = (n == 0) ? 2 : last_hs + n + 4;
        got = -1;
        for (int c = 0; c < 3000 && got < 0; c++) begin
            @(negedge clk);
            if (done || error) got = rel_cyc();
        end
        check("end_cycle", 32'(got),    32'(exp_end));
        check("done",      32'(done),   32'(exp_pass));
        check("enable",    32'(enable), 32'(exp_pass));
        check("error",     32'(error),  32'(!exp_pass));
        check("busy_end",  32'(busy),   32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        wr_q.delete();
        rd_q.delete();
    endtask

    task automatic check_all_outputs_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_wen"},     32'(wen_ext), 32'd0);
        check({tag, "_ren"},     32'(ren_ext), 32'd0);
        check({tag, "_addr"},    addr_ext,     32'd0);
        check({tag, "_wdata"},   wdata_ext,    32'd0);
        check({tag, "_enable"},  32'(enable),  32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_error"},   32'(error),   32'd0);
    endtask

    task automatic load_basic_image();
        img[0] = 32'h2001_0005;
        img[1] = 32'h2002_0003;
        img[2] = 32'h0022_1820;
        img[3] = 32'hAC03_0000;
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        arst_n    = 1'b0;
        start     = 1'b0;
        num_words = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        #12;
        check_all_outputs_zero("reset");
        #20;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic pass: writes in cycles 2-5, reads in 6-9, enable in 12.
        load_basic_image();
        run_load(4, 1'b0, 0, 1'b1);

        // Restart from RUN, with a stray start during LOAD that must be ignored.
        run_load(4, 1'b0, 2, 1'b1);

        // Stalled stream: 3 words, gaps on every other cycle, enable in 12.
        img[0] = 32'h1111_0001;
        img[1] = 32'h2222_0002;
        img[2] = 32'h3333_0003;
        run_load(3, 1'b1, 0, 1'b1);

        // Corrupt readback at 0x4 leads to FAIL.
        load_basic_image();
        corrupt = 1'b1;
        run_load(4, 1'b0, 0, 1'b0);
        corrupt = 1'b0;

        // Empty image from FAIL: CHECK in cycle 1, RUN in cycle 2, no strobes.
        run_load(0, 1'b0, 0, 1'b1);

        // Oversize image: FAIL in cycle 1.
        pulse_start(DEPTH + 1);
        @(negedge clk);
        check("oversize_error",  32'(error),   32'd1);
        check("oversize_busy",   32'(busy),    32'd0);
        check("oversize_enable", 32'(enable),  32'd0);
        check("oversize_ready",  32'(s_ready), 32'd0);

        // Full-depth image: last write at 0x7FC, then pass.
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, 1'b0, 0, 1'b1);

        // Reset during VERIFY, then reload cleanly.
        load_basic_image();
        pulse_start(4);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = img[i];
            wr_q.push_back('{addr: BASE + 32'(4*i), data: img[i], cyc: i + 2});
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        for (int j = 0; j < 4; j++)
            rd_q.push_back('{addr: BASE + 32'(4*j), data: 32'd0, cyc: 6 + j});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // Cycle 7: VERIFY with a read strobe active.
        check("pre_reset_busy", 32'(busy),    32'd1);
        check("pre_reset_ren",  32'(ren_ext), 32'd1);
        #1;
        arst_n = 1'b0;
        #1;
        check_all_outputs_zero("async_reset");
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(negedge clk);
        check("after_reset_busy", 32'(busy),  32'd0);
        check("after_reset_done", 32'(done),  32'd0);
        @(posedge clk);
        #1;
        run_load(4, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
